// File: rtl/core_trap_sequencer.sv
// Trap/return sequencer: stalls/flushes the pipe, writes mepc/mcause/mtval through a
// req/ack CSR port, then redirects the PC. Optional macro CORE_TRAP_TVAL_EN adds the mtval write.
module core_trap_sequencer #(
  parameter int unsigned IRQ_CAUSE = 11
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_ecall,
  input  logic        i_ebreak,
  input  logic        i_mret,
  input  logic        i_sret,
  input  logic        i_illegal,
  input  logic        i_irq,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic [1:0]  i_priv,
  input  logic [1:0]  i_mpp,
  input  logic        i_spp,
  input  logic [31:0] i_mepc,
  input  logic [31:0] i_sepc,
  input  logic [31:0] i_mtvec,
  input  logic        i_csr_ack,
  output logic        o_stall,
  output logic        o_flush,
  output logic        o_csr_wreq,
  output logic [11:0] o_csr_waddr,
  output logic [31:0] o_csr_wdata,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic [1:0]  o_priv_next,
  output logic [1:0]  o_xret,
  output logic        o_busy,
  output logic [2:0]  o_dbg_state
);

  // CSR write port: o_csr_wreq/o_csr_waddr/o_csr_wdata hold steady until a rising edge
  // sees i_csr_ack = 1; i_csr_ack may arrive combinationally and is ignored while o_csr_wreq is low.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_EPC   = 3'd1,
    WR_CAUSE = 3'd2,
`ifdef CORE_TRAP_TVAL_EN
    WR_TVAL  = 3'd3,
`endif
    REDIRECT = 3'd4,
    RET      = 3'd5
  } state_t;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
`ifdef CORE_TRAP_TVAL_EN
  localparam logic [11:0] CSR_MTVAL  = 12'h343;
`endif
  localparam logic [31:0] IRQ_MCAUSE = {1'b1, 31'(IRQ_CAUSE)};

  state_t      state_q, state_d;
  logic [31:0] epc_q, cause_q;
  logic        is_irq_q, is_sret_q, flush_q;

  logic        ev_trap, ev_xret, ev_sret, ev_irq;
  logic [31:0] ev_cause, ev_tval;
  logic [31:0] trap_target;

`ifdef CORE_TRAP_TVAL_EN
  logic [31:0] tval_q;
`else
  logic        unused_tval;
  assign unused_tval = ^{ev_tval};
`endif

  // Event decode; an xret lacking privilege becomes an illegal-instruction trap.
  always_comb begin
    ev_trap  = 1'b0;
    ev_xret  = 1'b0;
    ev_sret  = 1'b0;
    ev_irq   = 1'b0;
    ev_cause = 32'd0;
    ev_tval  = 32'd0;
    if (i_valid) begin
      if (i_illegal) begin
        ev_trap  = 1'b1;
        ev_cause = 32'd2;
        ev_tval  = i_instr;
      end else if (i_ecall) begin
        ev_trap  = 1'b1;
        case (i_priv)
          2'b00:   ev_cause = 32'd8;
          2'b01:   ev_cause = 32'd9;
          default: ev_cause = 32'd11;
        endcase
      end else if (i_ebreak) begin
        ev_trap  = 1'b1;
        ev_cause = 32'd3;
        ev_tval  = i_pc;
      end else if (i_mret) begin
        if (i_priv == 2'b11) begin
          ev_xret = 1'b1;
        end else begin
          ev_trap  = 1'b1;
          ev_cause = 32'd2;
          ev_tval  = i_instr;
        end
      end else if (i_sret) begin
        if (i_priv != 2'b00) begin
          ev_xret = 1'b1;
          ev_sret = 1'b1;
        end else begin
          ev_trap  = 1'b1;
          ev_cause = 32'd2;
          ev_tval  = i_instr;
        end
      end else if (i_irq) begin
        ev_trap  = 1'b1;
        ev_irq   = 1'b1;
        ev_cause = IRQ_MCAUSE;
      end
    end
  end

  // Vectored mode only applies to interrupts.
  always_comb begin
    trap_target = {i_mtvec[31:2], 2'b00};
    if (is_irq_q && (i_mtvec[1:0] == 2'b01)) begin
      trap_target = trap_target + {cause_q[29:0], 2'b00};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      epc_q     <= 32'd0;
      cause_q   <= 32'd0;
      is_irq_q  <= 1'b0;
      is_sret_q <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= (state_q == IDLE) && (ev_trap || ev_xret);
      if (state_q == IDLE) begin
        if (ev_trap) begin
          epc_q    <= i_pc;
          cause_q  <= ev_cause;
          is_irq_q <= ev_irq;
        end
        if (ev_xret) begin
          is_sret_q <= ev_sret;
        end
      end
    end
  end

`ifdef CORE_TRAP_TVAL_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tval_q <= 32'd0;
    end else if ((state_q == IDLE) && ev_trap) begin
      tval_q <= ev_tval;
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    o_stall       = 1'b0;
    o_csr_wreq    = 1'b0;
    o_csr_waddr   = 12'd0;
    o_csr_wdata   = 32'd0;
    o_redirect    = 1'b0;
    o_redirect_pc = 32'd0;
    o_priv_next   = 2'b11;
    o_xret        = 2'b00;
    case (state_q)
      IDLE: begin
        if (ev_trap) begin
          o_stall = 1'b1;
          state_d = WR_EPC;
        end else if (ev_xret) begin
          o_stall = 1'b1;
          state_d = RET;
        end
      end
      WR_EPC: begin
        o_stall     = 1'b1;
        o_csr_wreq  = 1'b1;
        o_csr_waddr = CSR_MEPC;
        o_csr_wdata = epc_q;
        if (i_csr_ack) state_d = WR_CAUSE;
      end
      WR_CAUSE: begin
        o_stall     = 1'b1;
        o_csr_wreq  = 1'b1;
        o_csr_waddr = CSR_MCAUSE;
        o_csr_wdata = cause_q;
`ifdef CORE_TRAP_TVAL_EN
        if (i_csr_ack) state_d = WR_TVAL;
`else
        if (i_csr_ack) state_d = REDIRECT;
`endif
      end
`ifdef CORE_TRAP_TVAL_EN
      WR_TVAL: begin
        o_stall     = 1'b1;
        o_csr_wreq  = 1'b1;
        o_csr_waddr = CSR_MTVAL;
        o_csr_wdata = tval_q;
        if (i_csr_ack) state_d = REDIRECT;
      end
`endif
      REDIRECT: begin
        o_stall       = 1'b1;
        o_redirect    = 1'b1;
        o_redirect_pc = trap_target;
        o_priv_next   = 2'b11;
        state_d       = IDLE;
      end
      RET: begin
        o_stall    = 1'b1;
        o_redirect = 1'b1;
        if (is_sret_q) begin
          o_redirect_pc = i_sepc;
          o_priv_next   = {1'b0, i_spp};
          o_xret        = 2'b10;
        end else begin
          o_redirect_pc = i_mepc;
          o_priv_next   = i_mpp;
          o_xret        = 2'b01;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_flush     = flush_q;
  assign o_busy      = (state_q != IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_core_trap_sequencer.sv
// Directed plus randomized bench for core_trap_sequencer against a rule-level reference model.
module tb_core_trap_sequencer;

`ifdef CORE_TRAP_TVAL_EN
  localparam bit TVAL_EN = 1'b1;
`else
  localparam bit TVAL_EN = 1'b0;
`endif
  localparam int unsigned IRQ_CODE = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ecall, i_ebreak, i_mret, i_sret, i_illegal, i_irq;
  logic [31:0] i_pc, i_instr, i_mepc, i_sepc, i_mtvec;
  logic [1:0]  i_priv, i_mpp;
  logic        i_spp, i_csr_ack;
  logic        o_stall, o_flush, o_csr_wreq, o_redirect, o_busy;
  logic [11:0] o_csr_waddr;
  logic [31:0] o_csr_wdata, o_redirect_pc;
  logic [1:0]  o_priv_next, o_xret;
  logic [2:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [43:0] exp_q[$];

  core_trap_sequencer #(.IRQ_CAUSE(IRQ_CODE)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_ecall(i_ecall), .i_ebreak(i_ebreak),
    .i_mret(i_mret), .i_sret(i_sret), .i_illegal(i_illegal), .i_irq(i_irq), .i_pc(i_pc),
    .i_instr(i_instr), .i_priv(i_priv), .i_mpp(i_mpp), .i_spp(i_spp), .i_mepc(i_mepc),
    .i_sepc(i_sepc), .i_mtvec(i_mtvec), .i_csr_ack(i_csr_ack), .o_stall(o_stall),
    .o_flush(o_flush), .o_csr_wreq(o_csr_wreq), .o_csr_waddr(o_csr_waddr),
    .o_csr_wdata(o_csr_wdata), .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_priv_next(o_priv_next), .o_xret(o_xret), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_events();
    i_valid = 0; i_ecall = 0; i_ebreak = 0; i_mret = 0; i_sret = 0; i_illegal = 0; i_irq = 0;
  endtask

  // Reference model: kind 0 = nothing, 1 = trap, 2 = xret.
  task automatic ref_model(output int kind, output logic [31:0] cause, output logic [31:0] tval,
                           output logic [31:0] target, output logic [1:0] pnext,
                           output logic [1:0] xret);
    bit is_irq;
    kind = 0; cause = 0; tval = 0; target = 0; pnext = 2'b11; xret = 2'b00; is_irq = 0;
    if (i_valid) begin
      if (i_illegal) begin kind = 1; cause = 2; tval = i_instr; end
      else if (i_ecall) begin kind = 1; cause = 8 + i_priv; end
      else if (i_ebreak) begin kind = 1; cause = 3; tval = i_pc; end
      else if (i_mret) begin
        if (i_priv == 3) begin kind = 2; target = i_mepc; pnext = i_mpp; xret = 2'b01; end
        else begin kind = 1; cause = 2; tval = i_instr; end
      end else if (i_sret) begin
        if (i_priv != 0) begin kind = 2; target = i_sepc; pnext = {1'b0, i_spp}; xret = 2'b10; end
        else begin kind = 1; cause = 2; tval = i_instr; end
      end else if (i_irq) begin
        kind = 1; is_irq = 1; cause = 32'h8000_0000 + IRQ_CODE;
      end
    end
    if (kind == 1) begin
      target = i_mtvec - (i_mtvec % 4);
      if (is_irq && (i_mtvec % 4 == 1)) target = target + 4 * IRQ_CODE;
    end
  endtask

  // Driver/monitor for one event: inputs are already applied just after a rising edge (cycle T).
  task automatic run_event(input int delay, input string tag);
    int kind, cyc, held, exp_cyc, nwr;
    logic [31:0] cause, tval, tgt;
    logic [1:0] pn, xr;
    bit done, acked;
    ref_model(kind, cause, tval, tgt, pn, xr);
    exp_q.delete();
    if (kind == 1) begin
      exp_q.push_back({12'h341, i_pc});
      exp_q.push_back({12'h342, cause});
      if (TVAL_EN) exp_q.push_back({12'h343, tval});
    end
    nwr = exp_q.size();
    exp_cyc = (kind == 2) ? 1 : nwr * (delay + 1) + 1;
    #1;
    chk({tag, "_stall_T"}, 32'(o_stall), 32'(kind != 0));
    chk({tag, "_busy_T"}, 32'(o_busy), 0);
    @(posedge clk); #1;
    clear_events();
    if (kind == 0) begin
      chk({tag, "_idle_busy"}, 32'(o_busy), 0);
      chk({tag, "_idle_flush"}, 32'(o_flush), 0);
      return;
    end
    cyc = 1; held = 0; done = 0;
    while (!done && cyc < 60) begin
      acked = 0;
      chk({tag, "_flush"}, 32'(o_flush), 32'(cyc == 1));
      chk({tag, "_stall"}, 32'(o_stall), 1);
      chk({tag, "_busy"}, 32'(o_busy), 1);
      if (o_redirect) begin
        chk({tag, "_redir_cycle"}, cyc, exp_cyc);
        chk({tag, "_redir_pc"}, o_redirect_pc, tgt);
        chk({tag, "_priv_next"}, 32'(o_priv_next), 32'(pn));
        chk({tag, "_xret"}, 32'(o_xret), 32'(xr));
        chk({tag, "_writes_left"}, exp_q.size(), 0);
        chk({tag, "_no_wreq"}, 32'(o_csr_wreq), 0);
        done = 1;
      end else if (o_csr_wreq) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_write"}, 32'(o_csr_waddr), 0);
        end else begin
          chk({tag, "_waddr"}, 32'(o_csr_waddr), 32'(exp_q[0][43:32]));
          chk({tag, "_wdata"}, o_csr_wdata, exp_q[0][31:0]);
        end
        chk({tag, "_no_redir"}, 32'(o_xret), 0);
        i_csr_ack = (held >= delay);
        acked = i_csr_ack;
      end else begin
        chk({tag, "_no_action"}, 32'(o_dbg_state), 32'hFFFF_FFFF);
        i_csr_ack = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (acked) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        held = 0;
      end else if (o_csr_wreq) begin
        held++;
      end
      i_csr_ack = 1'($urandom_range(0, 1));
      cyc++;
    end
    if (!done) chk({tag, "_timeout"}, 1, 0);
    i_csr_ack = 0;
    chk({tag, "_done_busy"}, 32'(o_busy), 0);
    chk({tag, "_done_redir"}, 32'(o_redirect), 0);
  endtask

  initial begin
    int r;
    rst = 1; i_csr_ack = 0; clear_events();
    i_pc = 0; i_instr = 0; i_priv = 2'b11; i_mpp = 0; i_spp = 0;
    i_mepc = 0; i_sepc = 0; i_mtvec = 0;
    #12;
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_flush", 32'(o_flush), 0);
    chk("rst_wreq", 32'(o_csr_wreq), 0);
    chk("rst_redirect", 32'(o_redirect), 0);
    chk("rst_priv", 32'(o_priv_next), 3);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_xret", 32'(o_xret), 0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    // ecall from U, zero-wait ack
    i_valid = 1; i_ecall = 1; i_priv = 2'b00; i_pc = 32'h100; i_mtvec = 32'h8000_0000;
    run_event(0, "ecall_u");

    // illegal, ack delayed by two cycles per write
    i_valid = 1; i_illegal = 1; i_instr = 32'hFFFF_FFFF; i_pc = 32'h0000_0444; i_priv = 2'b11;
    run_event(2, "illegal");

    // mret in M
    i_valid = 1; i_mret = 1; i_priv = 2'b11; i_mepc = 32'h200; i_mpp = 2'b00;
    run_event(0, "mret_m");

    // sret from U is illegal
    i_valid = 1; i_sret = 1; i_priv = 2'b00; i_instr = 32'h1020_0073; i_pc = 32'h0000_0880;
    run_event(1, "sret_u");

    // sret from S
    i_valid = 1; i_sret = 1; i_priv = 2'b01; i_sepc = 32'h0000_3000; i_spp = 1;
    run_event(0, "sret_s");

    // vectored interrupt
    i_valid = 1; i_irq = 1; i_mtvec = 32'h8000_0001; i_pc = 32'h0000_1234; i_priv = 2'b00;
    run_event(0, "irq_vec");

    // ecall beats a simultaneous interrupt
    i_valid = 1; i_irq = 1; i_ecall = 1; i_priv = 2'b01; i_pc = 32'h0000_2000;
    run_event(0, "ecall_irq");

    // flags without i_valid, and i_valid without flags
    i_ecall = 1; i_irq = 1;
    run_event(0, "no_valid");
    i_valid = 1;
    run_event(0, "no_flags");

    // reset asserted while in WR_CAUSE
    i_valid = 1; i_ecall = 1; i_priv = 2'b00; i_pc = 32'h100; i_mtvec = 32'h8000_0000;
    i_csr_ack = 1;
    @(posedge clk); #1; clear_events();
    @(posedge clk); #1;
    chk("mid_waddr", 32'(o_csr_waddr), 32'h342);
    rst = 1; #1;
    chk("mid_rst_stall", 32'(o_stall), 0);
    chk("mid_rst_wreq", 32'(o_csr_wreq), 0);
    chk("mid_rst_priv", 32'(o_priv_next), 3);
    chk("mid_rst_busy", 32'(o_busy), 0);
    chk("mid_rst_flush", 32'(o_flush), 0);
    @(posedge clk); #1; rst = 0; i_csr_ack = 0;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(o_busy), 0);
    chk("post_rst_wreq", 32'(o_csr_wreq), 0);

    // randomized events
    for (int n = 0; n < 60; n++) begin
      clear_events();
      i_valid = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 6);
      case (r)
        1: i_ecall = 1;
        2: i_ebreak = 1;
        3: i_mret = 1;
        4: i_sret = 1;
        5: i_illegal = 1;
        default: ;
      endcase
      i_irq = (r == 6) || ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0: i_priv = 2'b00;
        1: i_priv = 2'b01;
        default: i_priv = 2'b11;
      endcase
      case ($urandom_range(0, 2))
        0: i_mpp = 2'b00;
        1: i_mpp = 2'b01;
        default: i_mpp = 2'b11;
      endcase
      i_spp   = 1'($urandom_range(0, 1));
      i_pc    = $urandom() & 32'hFFFF_FFFC;
      i_instr = $urandom();
      i_mepc  = $urandom() & 32'hFFFF_FFFC;
      i_sepc  = $urandom() & 32'hFFFF_FFFC;
      i_mtvec = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 1));
      run_event($urandom_range(0, 2), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
